// File: rtl/gshare_pht_pkg.sv
// gshare_pht_pkg
//   Shared definitions for the gshare pattern history table: the 2-bit
//   counter encoding (common with the counter update FSM), the default
//   table geometry, the post-reset fill value and the PC bit where the
//   table index starts.
package gshare_pht_pkg;

    // Saturating branch counter, MSB is the taken prediction.
    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,  // strongly not-taken
        CNT_WNT = 2'b01,  // weakly not-taken
        CNT_WT  = 2'b10,  // weakly taken
        CNT_ST  = 2'b11   // strongly taken
    } cnt_e;

    localparam int          IDX_W_DEF    = 6;
    localparam int          CNT_W_DEF    = 2;
    localparam logic [1:0]  INIT_CNT_DEF = CNT_WNT;

    // Instructions are word aligned, so the index starts above the byte offset.
    localparam int          PC_IDX_LSB   = 2;

endpackage

// File: rtl/gshare_pht_mem.sv
// gshare_pht_mem
//   2^IDX_W x CNT_W counter array with one synchronous write port and two
//   registered read ports. A read that hits the address being written on
//   the same edge returns the new data (write-first).
//
// Ports
//   clk      clock
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr_a  read port A address (sampled at the edge)
//   rdata_a  read port A data, valid the cycle after the address edge
//   raddr_b  read port B address
//   rdata_b  read port B data
module gshare_pht_mem
    import gshare_pht_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [CNT_W-1:0] rdata_a,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [CNT_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << IDX_W;

    logic [CNT_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the owner fills it with a sweep after
    // reset, which keeps this a plain RAM. Non-blocking assignments keep the
    // read of the old contents and the write on the same edge ordered
    // correctly.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
        rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
    end

endmodule

// File: rtl/gshare_pht.sv
// gshare_pht
//   Gshare pattern history table. Lookups index the table with
//   PC ^ global history and return a prediction one cycle later. Resolved
//   branches read their entry, hand counter and outcome to the external
//   counter FSM, and commit the FSM's next counter two cycles after
//   acceptance. After reset every entry is swept to INIT_CNT before any
//   request is accepted.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   lkp_valid/lkp_pc      prediction request
//   lkp_ready             table accepts requests (sweep done)
//   pred_valid/taken/idx  prediction result, one cycle after acceptance
//   upd_valid/idx/taken   branch resolution
//   upd_ready             same as lkp_ready
//   fsm_torn/fsm_cnt      outcome and current counter to the FSM
//   fsm_wr_en/wr_data     FSM result, meaningful in the cycle after fsm_cnt
module gshare_pht
    import gshare_pht_pkg::*;
#(
    parameter int               IDX_W    = IDX_W_DEF,
    parameter int               PC_W     = 32,
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] INIT_CNT = INIT_CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lkp_valid,
    input  logic [PC_W-1:0]  lkp_pc,
    output logic             lkp_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             fsm_torn,
    output logic [CNT_W-1:0] fsm_cnt,
    input  logic             fsm_wr_en,
    input  logic [CNT_W-1:0] fsm_wr_data
);

    localparam int PC_IDX_MSB = PC_IDX_LSB + IDX_W - 1;

    logic             init_busy;
    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] ghr;

    logic             lkp_fire;
    logic             upd_fire;
    logic [IDX_W-1:0] lkp_idx;

    // Update pipeline: stage 1 is the FSM evaluation cycle, stage 2 the
    // write-back cycle.
    logic             v1, v2;
    logic [IDX_W-1:0] idx1, idx2;
    logic             torn1;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [CNT_W-1:0] mem_wdata;
    logic [CNT_W-1:0] rd_lkp;
    logic [CNT_W-1:0] rd_upd;

    // PC bits outside the index field do not take part in the hash.
    logic unused_pc;
    assign unused_pc = ^{lkp_pc[PC_W-1:PC_IDX_MSB+1], lkp_pc[PC_IDX_LSB-1:0]};

    assign lkp_ready = !init_busy;
    assign upd_ready = !init_busy;
    assign lkp_fire  = lkp_valid && !init_busy;
    assign upd_fire  = upd_valid && !init_busy;
    assign lkp_idx   = lkp_pc[PC_IDX_MSB:PC_IDX_LSB] ^ ghr;

    // Single write port: the sweep owns it while busy; afterwards only a
    // stage-2 FSM result may write. The FSM's wr_en is free-running, so it
    // is qualified with v2 here. Nothing commits on a reset edge.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_cnt;
        mem_wdata = INIT_CNT;
        if (reset) begin
            mem_we = 1'b0;
        end else if (init_busy) begin
            mem_we = 1'b1;
        end else if (v2 && fsm_wr_en) begin
            mem_we    = 1'b1;
            mem_waddr = idx2;
            mem_wdata = fsm_wr_data;
        end
    end

    gshare_pht_mem #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (lkp_idx),
        .rdata_a (rd_lkp),
        .raddr_b (upd_idx),
        .rdata_b (rd_upd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            init_busy  <= 1'b1;
            init_cnt   <= '0;
            ghr        <= '0;
            pred_valid <= 1'b0;
            pred_idx   <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            idx1       <= '0;
            idx2       <= '0;
            torn1      <= 1'b0;
        end else begin
            if (init_busy) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == '1) begin
                    init_busy <= 1'b0;
                end
            end

            pred_valid <= lkp_fire;
            if (lkp_fire) begin
                pred_idx <= lkp_idx;
            end

            // Lookups on this edge already used the old history above.
            v1 <= upd_fire;
            if (upd_fire) begin
                idx1  <= upd_idx;
                torn1 <= upd_taken;
                ghr   <= {ghr[IDX_W-2:0], upd_taken};
            end

            v2   <= v1;
            idx2 <= idx1;
        end
    end

    // The read counter is meaningless without a prediction, so the output is
    // held low otherwise.
    assign pred_taken = pred_valid && rd_lkp[CNT_W-1];
    assign fsm_torn   = torn1;

    // An older update to the same entry that is committing now was not yet
    // in the array when this one was read: take its result directly.
    assign fsm_cnt = (v2 && fsm_wr_en && (idx2 == idx1)) ? fsm_wr_data : rd_upd;

endmodule
